signal_gen: RTL and testbench

Registered value-match detector. It compares an unsigned count input `num` against a compile-time constant `NUM_VALUE` and raises `signal` while a match holds. It also provides a match-entry pulse and a saturating match counter. It sits beside FIFO pointer and occupancy counters, where it generates threshold flags such as full, empty and almost-full.

---
 rtl/signal_gen_pkg.sv | 15 +
 rtl/signal_gen_edge.sv | 38 +++
 rtl/signal_gen.sv | 53 +++++
 tb/tb_signal_gen.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/signal_gen_pkg.sv
// Shared defaults and elaboration-time helpers for the signal_gen value-match detector.
package signal_gen_pkg;

   localparam int DEFAULT_NUM_WIDTH = 3;
   localparam int DEFAULT_NUM_VALUE = 7;
   localparam int DEFAULT_CNT_WIDTH = 8;

   // True when an unsigned constant is representable in the given number of bits.
   function automatic bit value_fits(input int value, input int width);
      if (value < 0) return 1'b0;
      if (width >= 31) return 1'b1;
      return (value >> width) == 0;
   endfunction

endpackage

// File: rtl/signal_gen_edge.sv
// Rise detector on a level input plus a saturating counter of detected rises.
module signal_gen_edge
   import signal_gen_pkg::*;
#(
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 level,
   output logic                 rise,
   output logic [CNT_WIDTH-1:0] count
);

   logic                 level_q;
   logic [CNT_WIDTH-1:0] count_next;

   // NOTE: default assigned first so no path through this block leaves count_next unassigned (no latch).
   always_comb begin
      count_next = count;
      if (rise && (count != '1)) begin
         count_next = count + 1'b1;
      end
   end

   // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
   always_ff @(posedge clk) begin
      if (rst) begin
         level_q <= 1'b0;
         rise    <= 1'b0;
         count   <= '0;
      end else begin
         level_q <= level;
         rise    <= level & ~level_q;
         count   <= count_next;
      end
   end

endmodule

// File: rtl/signal_gen.sv
// Registered value-match detector: flags num == NUM_VALUE, pulses on match entry, counts entries.
module signal_gen
   import signal_gen_pkg::*;
#(
   parameter int NUM_WIDTH = DEFAULT_NUM_WIDTH,
   parameter int NUM_VALUE = DEFAULT_NUM_VALUE,
   parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_WIDTH-1:0] num,
   output logic                 signal,
   output logic                 signal_rise,
   output logic [CNT_WIDTH-1:0] match_count
);

   if (NUM_WIDTH < 1) begin : g_bad_num_width
      $error("signal_gen: NUM_WIDTH must be at least 1");
   end
   if (CNT_WIDTH < 1) begin : g_bad_cnt_width
      $error("signal_gen: CNT_WIDTH must be at least 1");
   end
   if (!value_fits(NUM_VALUE, NUM_WIDTH)) begin : g_bad_num_value
      $error("signal_gen: NUM_VALUE does not fit in NUM_WIDTH bits");
   end

   localparam logic [NUM_WIDTH-1:0] MATCH_VALUE = NUM_WIDTH'(NUM_VALUE);

   logic match;

   // Full-width unsigned compare; the constant is sized to num, never the other way round.
   assign match = (num == MATCH_VALUE);

   always_ff @(posedge clk) begin
      if (rst) begin
         signal <= 1'b0;
      end else begin
         signal <= match;
      end
   end

   // The edge block keeps its own delayed copy of match so the pulse lines up with signal.
   signal_gen_edge #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_edge (
      .clk  (clk),
      .rst  (rst),
      .level(match),
      .rise (signal_rise),
      .count(match_count)
   );

endmodule

// File: tb/tb_signal_gen.sv
// Directed self-checking bench for signal_gen across three parameterisations.
module tb_signal_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;

   logic [2:0] num_a = '0;
   logic       sig_a, rise_a;
   logic [7:0] cnt_a;

   logic [2:0] num_c = '0;
   logic       sig_c, rise_c;
   logic [1:0] cnt_c;

   logic [2:0] num_z = 3'd1;
   logic       sig_z, rise_z;
   logic [7:0] cnt_z;

   int compared   = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   signal_gen #(.NUM_WIDTH(3), .NUM_VALUE(7), .CNT_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst), .num(num_a),
      .signal(sig_a), .signal_rise(rise_a), .match_count(cnt_a)
   );

   signal_gen #(.NUM_WIDTH(3), .NUM_VALUE(7), .CNT_WIDTH(2)) dut_c (
      .clk(clk), .rst(rst), .num(num_c),
      .signal(sig_c), .signal_rise(rise_c), .match_count(cnt_c)
   );

   signal_gen #(.NUM_WIDTH(3), .NUM_VALUE(0), .CNT_WIDTH(8)) dut_z (
      .clk(clk), .rst(rst), .num(num_z),
      .signal(sig_z), .signal_rise(rise_z), .match_count(cnt_z)
   );

   // Advance one active edge and settle; inputs change here, away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      num_a = 3'd7;
      for (int k = 0; k < 3; k++) begin
         step();
         compared++;
         if ({sig_a, rise_a, cnt_a} !== 10'd0) begin
            mismatched++;
            $display("FAIL reset_hold cyc=%0d got sig=%b rise=%b cnt=%0d want 0/0/0", k, sig_a, rise_a, cnt_a);
         end
      end
      rst = 1'b0;
      step();
      compared++;
      if (sig_a !== 1'b1 || rise_a !== 1'b1 || cnt_a !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_release got sig=%b rise=%b cnt=%0d want 1/1/0", sig_a, rise_a, cnt_a);
      end
      step();
      compared++;
      if (sig_a !== 1'b1 || rise_a !== 1'b0 || cnt_a !== 8'd1) begin
         mismatched++;
         $display("FAIL reset_release_next got sig=%b rise=%b cnt=%0d want 1/0/1", sig_a, rise_a, cnt_a);
      end
   endtask

   task automatic test_wrap();
      logic       exp_sig;
      logic [7:0] exp_cnt;
      num_a = 3'd0;
      do_reset();
      exp_cnt = 8'd0;
      for (int k = 0; k < 24; k++) begin
         num_a = 3'(k % 8);
         step();
         exp_sig = ((k % 8) == 7);
         compared++;
         if (sig_a !== exp_sig || rise_a !== exp_sig || cnt_a !== exp_cnt) begin
            mismatched++;
            $display("FAIL wrap edge=%0d got sig=%b rise=%b cnt=%0d want %b/%b/%0d",
                     k, sig_a, rise_a, cnt_a, exp_sig, exp_sig, exp_cnt);
         end
         if (exp_sig) exp_cnt = exp_cnt + 8'd1;
      end
   endtask

   task automatic test_hold();
      num_a = 3'd0;
      do_reset();
      step();
      for (int k = 0; k < 5; k++) begin
         num_a = 3'd7;
         step();
         compared++;
         if (sig_a !== 1'b1 || rise_a !== (k == 0) || cnt_a !== ((k == 0) ? 8'd0 : 8'd1)) begin
            mismatched++;
            $display("FAIL hold cyc=%0d got sig=%b rise=%b cnt=%0d want 1/%b/%0d",
                     k, sig_a, rise_a, cnt_a, (k == 0), (k == 0) ? 0 : 1);
         end
      end
      num_a = 3'd0;
      step();
      compared++;
      if (sig_a !== 1'b0 || rise_a !== 1'b0 || cnt_a !== 8'd1) begin
         mismatched++;
         $display("FAIL hold_exit got sig=%b rise=%b cnt=%0d want 0/0/1", sig_a, rise_a, cnt_a);
      end
   endtask

   task automatic test_reset_during_match();
      num_a = 3'd0;
      do_reset();
      num_a = 3'd7;
      step();
      compared++;
      if (sig_a !== 1'b1) begin
         mismatched++;
         $display("FAIL rst_in_match_pre got sig=%b want 1", sig_a);
      end
      rst = 1'b1;
      step();
      compared++;
      if (sig_a !== 1'b0 || rise_a !== 1'b0 || cnt_a !== 8'd0) begin
         mismatched++;
         $display("FAIL rst_in_match got sig=%b rise=%b cnt=%0d want 0/0/0", sig_a, rise_a, cnt_a);
      end
      rst   = 1'b0;
      num_a = 3'd0;
   endtask

   task automatic test_saturate();
      logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      num_c = 3'd0;
      do_reset();
      for (int m = 0; m < 5; m++) begin
         num_c = 3'd7;
         step();
         num_c = 3'd0;
         step();
         compared++;
         if (cnt_c !== exp_cnt[m] || sig_c !== 1'b0) begin
            mismatched++;
            $display("FAIL saturate match=%0d got cnt=%0d sig=%b want cnt=%0d sig=0",
                     m, cnt_c, sig_c, exp_cnt[m]);
         end
      end
   endtask

   task automatic test_zero();
      logic       exp_sig;
      logic [7:0] exp_cnt;
      num_z = 3'd1;
      do_reset();
      exp_cnt = 8'd0;
      for (int k = 0; k < 8; k++) begin
         num_z = 3'(k % 2);
         step();
         exp_sig = ((k % 2) == 0);
         compared++;
         if (sig_z !== exp_sig || rise_z !== exp_sig || cnt_z !== exp_cnt) begin
            mismatched++;
            $display("FAIL zero_match edge=%0d got sig=%b rise=%b cnt=%0d want %b/%b/%0d",
                     k, sig_z, rise_z, cnt_z, exp_sig, exp_sig, exp_cnt);
         end
         if (exp_sig) exp_cnt = exp_cnt + 8'd1;
      end
   endtask

   initial begin
      test_reset();
      test_wrap();
      test_hold();
      test_reset_during_match();
      test_saturate();
      test_zero();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
